// File: rtl/pipeline_debug_ctrl.sv
// Run/step/breakpoint controller for the 5-stage core.
// Gates fetch in free-run, single-step, N-step and run-to-breakpoint modes,
// drains the pipeline before halting and counts retired instructions.
module pipeline_debug_ctrl #(
    parameter int PC_W            = 32,
    parameter int NUM_BP          = 2,
    parameter int STEP_W          = 8,
    parameter int CNT_W           = 16,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int OUTST_W         = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               mode,
    input  logic                     step_button,
    input  logic [STEP_W-1:0]        step_count,
    input  logic [NUM_BP-1:0]        bp_en,
    input  logic [NUM_BP*PC_W-1:0]   bp_addr,
    input  logic [PC_W-1:0]          pc_f,
    input  logic                     instr_completed,
    output logic                     fetch_enable,
    output logic                     halted,
    output logic                     step_done,
    output logic [NUM_BP-1:0]        bp_hit,
    output logic [CNT_W-1:0]         retired_count
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [1:0] MODE_RUN    = 2'b00;
    localparam logic [1:0] MODE_STEP   = 2'b01;
    localparam logic [1:0] MODE_STEP_N = 2'b10;
    localparam logic [1:0] MODE_BREAK  = 2'b11;
    localparam logic [OUTST_W-1:0] INFLIGHT_MAX = {OUTST_W{1'b1}};

    typedef enum logic [1:0] {
        ST_HALT    = 2'd0,
        ST_RUNNING = 2'd1,
        ST_ISSUE   = 2'd2,
        ST_DRAIN   = 2'd3
    } state_t;

    state_t              state_r;
    state_t              next_state_s;
    logic [1:0]          sync_r;
    logic                cand_r;
    logic                level_r;
    logic [DB_W-1:0]     db_cnt_r;
    logic                press_r;
    logic [STEP_W-1:0]   remaining_r;
    logic                skip_bp_r;
    logic [NUM_BP-1:0]   bp_hit_r;
    logic                step_done_r;
    logic                halted_r;
    logic [OUTST_W-1:0]  inflight_r;
    logic [OUTST_W-1:0]  inflight_nxt_s;
    logic [CNT_W-1:0]    retired_r;
    logic [NUM_BP-1:0]   bp_vec_s;
    logic                bp_kill_s;
    logic                fetch_enable_s;

    // Synchronise the raw button, debounce it and emit a one-cycle pulse on an accepted rising edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r   <= 2'b00;
            cand_r   <= 1'b0;
            level_r  <= 1'b0;
            db_cnt_r <= {DB_W{1'b0}};
            press_r  <= 1'b0;
        end else begin
            sync_r  <= {sync_r[0], step_button};
            press_r <= 1'b0;
            if (sync_r[1] != cand_r) begin
                cand_r   <= sync_r[1];
                db_cnt_r <= {DB_W{1'b0}};
            end else if (cand_r != level_r) begin
                if (db_cnt_r == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    level_r  <= cand_r;
                    press_r  <= cand_r;
                    db_cnt_r <= {DB_W{1'b0}};
                end else begin
                    db_cnt_r <= db_cnt_r + DB_W'(1);
                end
            end
        end
    end

    // Per-comparator breakpoint match; disabled comparators never match.
    always_comb begin
        bp_vec_s = {NUM_BP{1'b0}};
        for (int i = 0; i < NUM_BP; i++) begin
            if (bp_en[i] && (pc_f == bp_addr[i*PC_W +: PC_W])) begin
                bp_vec_s[i] = 1'b1;
            end else begin
                bp_vec_s[i] = 1'b0;
            end
        end
    end

    assign bp_kill_s = (state_r == ST_RUNNING) && (mode == MODE_BREAK) &&
                       (|bp_vec_s) && !skip_bp_r;

    // Fetch gate: state decode, with a same-cycle kill when a breakpoint is hit.
    always_comb begin
        fetch_enable_s = 1'b0;
        case (state_r)
            ST_HALT:    fetch_enable_s = 1'b0;
            ST_RUNNING: fetch_enable_s = !bp_kill_s;
            ST_ISSUE:   fetch_enable_s = 1'b1;
            ST_DRAIN:   fetch_enable_s = 1'b0;
            default:    fetch_enable_s = 1'b0;
        endcase
    end

    // In-flight tracking: saturating up on fetch, floored at zero on retire.
    always_comb begin
        inflight_nxt_s = inflight_r;
        if (fetch_enable_s && !instr_completed) begin
            if (inflight_r != INFLIGHT_MAX) begin
                inflight_nxt_s = inflight_r + OUTST_W'(1);
            end else begin
                inflight_nxt_s = inflight_r;
            end
        end else if (!fetch_enable_s && instr_completed) begin
            if (inflight_r != {OUTST_W{1'b0}}) begin
                inflight_nxt_s = inflight_r - OUTST_W'(1);
            end else begin
                inflight_nxt_s = inflight_r;
            end
        end else begin
            inflight_nxt_s = inflight_r;
        end
    end

    // Next-state logic; mode is only looked at in HALT and RUNNING.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_HALT: begin
                if (mode == MODE_RUN) begin
                    next_state_s = ST_RUNNING;
                end else if (press_r && ((mode == MODE_STEP) || (mode == MODE_STEP_N))) begin
                    next_state_s = ST_ISSUE;
                end else if (press_r && (mode == MODE_BREAK)) begin
                    next_state_s = ST_RUNNING;
                end else begin
                    next_state_s = ST_HALT;
                end
            end
            ST_RUNNING: begin
                if (bp_kill_s) begin
                    next_state_s = ST_DRAIN;
                end else if ((mode == MODE_STEP) || (mode == MODE_STEP_N)) begin
                    next_state_s = ST_DRAIN;
                end else begin
                    next_state_s = ST_RUNNING;
                end
            end
            ST_ISSUE: begin
                if (remaining_r <= STEP_W'(1)) begin
                    next_state_s = ST_DRAIN;
                end else begin
                    next_state_s = ST_ISSUE;
                end
            end
            ST_DRAIN: begin
                if (inflight_nxt_s == {OUTST_W{1'b0}}) begin
                    next_state_s = ST_HALT;
                end else begin
                    next_state_s = ST_DRAIN;
                end
            end
            default: next_state_s = ST_HALT;
        endcase
    end

    // State register, step bookkeeping, sticky breakpoint flags and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_HALT;
            remaining_r <= {STEP_W{1'b0}};
            skip_bp_r   <= 1'b0;
            bp_hit_r    <= {NUM_BP{1'b0}};
            step_done_r <= 1'b0;
            halted_r    <= 1'b1;
            inflight_r  <= {OUTST_W{1'b0}};
            retired_r   <= {CNT_W{1'b0}};
        end else begin
            state_r     <= next_state_s;
            inflight_r  <= inflight_nxt_s;
            step_done_r <= (state_r == ST_DRAIN) && (next_state_s == ST_HALT);
            halted_r    <= (next_state_s == ST_HALT);
            if (instr_completed) begin
                retired_r <= retired_r + CNT_W'(1);
            end
            case (state_r)
                ST_HALT: begin
                    if (press_r && (mode == MODE_STEP)) begin
                        remaining_r <= STEP_W'(1);
                    end else if (press_r && (mode == MODE_STEP_N)) begin
                        if (step_count == {STEP_W{1'b0}}) begin
                            remaining_r <= STEP_W'(1);
                        end else begin
                            remaining_r <= step_count;
                        end
                    end else if (press_r && (mode == MODE_BREAK)) begin
                        skip_bp_r <= 1'b1;
                        bp_hit_r  <= {NUM_BP{1'b0}};
                    end
                end
                ST_RUNNING: begin
                    skip_bp_r <= 1'b0;
                    if (bp_kill_s) begin
                        bp_hit_r <= bp_hit_r | bp_vec_s;
                    end
                end
                ST_ISSUE: remaining_r <= remaining_r - STEP_W'(1);
                ST_DRAIN: remaining_r <= remaining_r;
                default:  remaining_r <= {STEP_W{1'b0}};
            endcase
        end
    end

    assign fetch_enable  = fetch_enable_s;
    assign halted        = halted_r;
    assign step_done     = step_done_r;
    assign bp_hit        = bp_hit_r;
    assign retired_count = retired_r;

endmodule

// File: tb/tb_pipeline_debug_ctrl.sv
// Bench for pipeline_debug_ctrl: random step/break operations, a fetch/writeback
// environment with random retire latency, and a scoreboard checked on each step_done.
module tb_pipeline_debug_ctrl;

    localparam int CNT_W = 6;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [1:0]        mode = 2'b00;
    logic              step_button = 1'b0;
    logic [7:0]        step_count = 8'd0;
    logic [1:0]        bp_en = 2'b00;
    logic [63:0]       bp_addr = 64'd0;
    logic [31:0]       pc_f = 32'd0;
    logic              instr_completed = 1'b0;
    logic              fetch_enable;
    logic              halted;
    logic              step_done;
    logic [1:0]        bp_hit;
    logic [CNT_W-1:0]  retired_count;

    pipeline_debug_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .mode(mode), .step_button(step_button),
        .step_count(step_count), .bp_en(bp_en), .bp_addr(bp_addr), .pc_f(pc_f),
        .instr_completed(instr_completed), .fetch_enable(fetch_enable),
        .halted(halted), .step_done(step_done), .bp_hit(bp_hit),
        .retired_count(retired_count)
    );

    always #5 clk = ~clk;

    typedef struct { int fetches; logic [1:0] bp; } exp_t;
    exp_t sb_q[$];
    exp_t e;

    int checks = 0, failures = 0;
    int fcnt = 0, model_out = 0, done_cnt = 0;
    logic [CNT_W-1:0] exp_ret = '0;
    logic fe_seen = 1'b0, prev_halted = 1'b1;
    logic [1:0] exp_bp = 2'b00;
    int cyc = 0, last_due = 0, due;
    int rq[$];
    logic [31:0] pc = 32'd0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Environment: fetch advances pc, writeback retires each fetched instruction 2..5 cycles later, in order.
    always @(posedge clk) begin
        #2;
        cyc++;
        if (rst) begin
            rq.delete();
            pc = 32'd0;
            last_due = 0;
            instr_completed = 1'b0;
        end else begin
            if (fe_seen) begin
                pc = pc + 32'd4;
                due = cyc + $urandom_range(2, 5);
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                rq.push_back(due);
            end
            if (rq.size() > 0 && rq[0] <= cyc) begin
                void'(rq.pop_front());
                instr_completed = 1'b1;
            end else begin
                instr_completed = 1'b0;
            end
        end
        pc_f = pc;
    end

    // Monitor: reference counters and scoreboard pop on every step_done.
    always @(negedge clk) begin
        if (rst) begin
            sb_q.delete();
            fcnt = 0;
            model_out = 0;
            exp_ret = '0;
            fe_seen = 1'b0;
            prev_halted = 1'b1;
        end else begin
            chk("retired_count", retired_count, exp_ret);
            if (halted) chk("fetch_while_halted", fetch_enable, 0);
            if (step_done) begin
                chk("step_done_single_pulse", prev_halted, 0);
                chk("halted_at_done", halted, 1);
                chk("inflight_at_done", model_out, 0);
                if (sb_q.size() == 0) begin
                    chk("unexpected_step_done", step_done, 0);
                end else begin
                    e = sb_q.pop_front();
                    if (e.fetches >= 0) chk("fetch_count", fcnt, e.fetches);
                    chk("bp_hit", bp_hit, e.bp);
                end
                fcnt = 0;
                done_cnt++;
            end
            if (fetch_enable) fcnt++;
            model_out = model_out + (fetch_enable ? 1 : 0);
            if (instr_completed && model_out > 0) model_out--;
            exp_ret = exp_ret + CNT_W'(instr_completed);
            fe_seen = fetch_enable;
            prev_halted = halted;
        end
    end

    task automatic press();
        for (int i = 0; i < 3; i++) begin
            step_button = ~step_button;
            @(posedge clk); #1;
        end
        step_button = 1'b1;
        repeat (24) begin @(posedge clk); #1; end
        step_button = 1'b0;
        repeat (24) begin @(posedge clk); #1; end
    endtask

    task automatic wait_done(input int target, input string name);
        int n = 0;
        while (done_cnt < target && n < 600) begin
            @(posedge clk); #1;
            n++;
        end
        chk({name, "_timeout"}, (done_cnt >= target) ? 1 : 0, 1);
    endtask

    task automatic do_op(input int n, input logic [1:0] bp, input string name);
        int target = done_cnt + 1;
        exp_t x;
        x.fetches = n;
        x.bp = bp;
        sb_q.push_back(x);
        press();
        wait_done(target, name);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_halted"}, halted, 1);
        chk({tag, "_fetch_enable"}, fetch_enable, 0);
        chk({tag, "_step_done"}, step_done, 0);
        chk({tag, "_bp_hit"}, bp_hit, 0);
        chk({tag, "_retired"}, retired_count, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, sc, target;
        exp_t x;
        // Reset with RUN held, then free-run long enough to wrap the retire counter.
        mode = 2'b00;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_values("reset");
        @(negedge clk);
        chk("run_fetch_enable", fetch_enable, 1);
        chk("run_halted", halted, 0);
        @(posedge clk); #1;
        repeat (80) begin @(posedge clk); #1; end
        target = done_cnt + 1;
        x.fetches = -1; x.bp = exp_bp; sb_q.push_back(x);
        mode = 2'b01;
        wait_done(target, "run_stop");

        // Single steps.
        for (int i = 0; i < 3; i++) do_op(1, exp_bp, "step");

        // N-steps including the zero-means-one case.
        mode = 2'b10;
        for (int i = 0; i < 3; i++) begin
            sc = (i == 0) ? 5 : (i == 1) ? 0 : $urandom_range(1, 12);
            step_count = 8'(sc);
            do_op((sc == 0) ? 1 : sc, exp_bp, "step_n");
        end

        // Run to breakpoint; comparator 1 sits on the path but is disabled.
        mode = 2'b01;
        k = $urandom_range(3, 10);
        bp_addr[31:0] = pc + 32'(4 * k);
        bp_addr[63:32] = pc + 32'd4;
        bp_en = 2'b01;
        mode = 2'b11;
        exp_bp = 2'b01;
        do_op(k, exp_bp, "break0");
        // Resume from the breakpoint PC without re-hitting it, stop at comparator 1.
        bp_addr[63:32] = bp_addr[31:0] + 32'h20;
        bp_en = 2'b11;
        exp_bp = 2'b10;
        do_op(8, exp_bp, "break1");
        // Both comparators on the same PC.
        k = $urandom_range(1, 6);
        bp_addr[31:0] = pc + 32'(4 * k);
        bp_addr[63:32] = pc + 32'(4 * k);
        exp_bp = 2'b11;
        do_op(k, exp_bp, "break_both");
        mode = 2'b01;

        // A press while running is dropped, not replayed on the next halt.
        mode = 2'b00;
        repeat (3) begin @(posedge clk); #1; end
        press();
        target = done_cnt + 1;
        x.fetches = -1; x.bp = exp_bp; sb_q.push_back(x);
        mode = 2'b01;
        wait_done(target, "run_press_stop");
        repeat (60) begin @(posedge clk); #1; end
        chk("dropped_press_no_fetch", fcnt, 0);
        chk("dropped_press_halted", halted, 1);

        // Reset in the middle of an N-step.
        mode = 2'b10;
        step_count = 8'd6;
        x.fetches = 6; x.bp = exp_bp; sb_q.push_back(x);
        fork
            press();
            begin
                int n = 0;
                while (fcnt < 3 && n < 200) begin @(posedge clk); #1; n++; end
                chk("mid_step_reached", fcnt, 3);
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                @(negedge clk);
                check_reset_values("mid_reset");
            end
        join
        exp_bp = 2'b00;
        repeat (40) begin @(posedge clk); #1; end
        chk("after_reset_no_fetch", fcnt, 0);
        chk("after_reset_halted", halted, 1);
        step_count = 8'd3;
        do_op(3, exp_bp, "recover");

        repeat (10) begin @(posedge clk); #1; end
        chk("scoreboard_empty", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
